// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory-access stage and the MA/RW pipeline latch.
// The latch struct is also consumed by the write-back stage.
package memory_access_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_W   = 4;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_WAIT = 1'b1
    } ma_state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] aluresult;
        logic [DEF_DATA_W-1:0] ldresult;
        logic [31:0]           pc;
        logic [DEF_RD_W-1:0]   rd;
        logic                  iswb;
        logic                  isld;
        logic                  iscall;
    } ma_rw_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/memory_access_stage_ma_rw_latch.sv
// MA/RW pipeline register: loads a full latch word when enabled, otherwise holds.
module ma_rw_latch
    import memory_access_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  ma_rw_t d,
    output ma_rw_t q
);

    ma_rw_t q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access stage: issues data-memory requests, stalls execute while an
// access is outstanding, and retires every instruction into the MA/RW latch.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RD_W        = DEF_RD_W,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_aluresult,
    input  logic [DATA_W-1:0] ex_op2,
    input  logic [31:0]       ex_pc,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              ex_isld,
    input  logic              ex_isst,
    input  logic              ex_iswb,
    input  logic              ex_iscall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [31:0]       dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              rw_valid,
    output logic [DATA_W-1:0] rw_aluresult,
    output logic [DATA_W-1:0] rw_ldresult,
    output logic [31:0]       rw_pc,
    output logic [RD_W-1:0]   rw_rd,
    output logic              rw_iswb,
    output logic              rw_isld,
    output logic              rw_iscall,
    output logic              mem_error
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    ma_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    ma_rw_t            cap_q, cap_d;
    logic              rw_valid_q, rw_valid_d;
    logic              err_q, err_d;

    logic   rw_load;
    ma_rw_t rw_next;
    ma_rw_t rw_word;
    ma_rw_t ex_word;

    assign ex_word = '{aluresult: ex_aluresult, ldresult: '0, pc: ex_pc,
                       rd: ex_rd, iswb: ex_iswb, isld: ex_isld, iscall: ex_iscall};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cap_d      = cap_q;
        rw_valid_d = 1'b0;
        err_d      = err_q;
        rw_load    = 1'b0;
        rw_next    = cap_q;

        case (state_q)
            MA_IDLE: begin
                if (ex_valid) begin
                    if (ex_isld || ex_isst) begin
                        if (is_word_aligned(ex_aluresult[1:0])) begin
                            req_d   = 1'b1;
                            we_d    = ex_isst;
                            addr_d  = ex_aluresult;
                            wdata_d = ex_op2;
                            cap_d   = ex_word;
                            cnt_d   = '0;
                            state_d = MA_WAIT;
                        end else begin
                            // Misaligned access retires immediately without a write-back.
                            rw_load      = 1'b1;
                            rw_next      = ex_word;
                            rw_next.iswb = 1'b0;
                            rw_valid_d   = 1'b1;
                            err_d        = 1'b1;
                        end
                    end else begin
                        rw_load    = 1'b1;
                        rw_next    = ex_word;
                        rw_valid_d = 1'b1;
                    end
                end
            end
            MA_WAIT: begin
                if (dmem_ack) begin
                    req_d            = 1'b0;
                    rw_load          = 1'b1;
                    rw_next          = cap_q;
                    rw_next.ldresult = (cap_q.isld && !we_q) ? dmem_rdata : '0;
                    rw_valid_d       = 1'b1;
                    state_d          = MA_IDLE;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    req_d        = 1'b0;
                    rw_load      = 1'b1;
                    rw_next      = cap_q;
                    rw_next.iswb = 1'b0;
                    rw_valid_d   = 1'b1;
                    err_d        = 1'b1;
                    state_d      = MA_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MA_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_q      <= '0;
            rw_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_q      <= cap_d;
            rw_valid_q <= rw_valid_d;
            err_q      <= err_d;
        end
    end

    ma_rw_latch u_rw_latch (
        .clk   (clk),
        .reset (reset),
        .load  (rw_load),
        .d     (rw_next),
        .q     (rw_word)
    );

    assign ex_ready     = (state_q == MA_IDLE);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign rw_valid     = rw_valid_q;
    assign rw_aluresult = rw_word.aluresult;
    assign rw_ldresult  = rw_word.ldresult;
    assign rw_pc        = rw_word.pc;
    assign rw_rd        = rw_word.rd;
    assign rw_iswb      = rw_word.iswb;
    assign rw_isld      = rw_word.isld;
    assign rw_iscall    = rw_word.iscall;
    assign mem_error    = err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: a transaction-level model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_memory_access_stage;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_aluresult, ex_op2, ex_pc;
    logic [3:0]  ex_rd;
    logic        ex_isld, ex_isst, ex_iswb, ex_iscall;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        rw_valid;
    logic [31:0] rw_aluresult, rw_ldresult, rw_pc;
    logic [3:0]  rw_rd;
    logic        rw_iswb, rw_isld, rw_iscall;
    logic        mem_error;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    memory_access_stage #(.DATA_W(32), .RD_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluresult(ex_aluresult), .ex_op2(ex_op2), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_isld(ex_isld), .ex_isst(ex_isst), .ex_iswb(ex_iswb), .ex_iscall(ex_iscall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rw_valid(rw_valid), .rw_aluresult(rw_aluresult), .rw_ldresult(rw_ldresult),
        .rw_pc(rw_pc), .rw_rd(rw_rd), .rw_iswb(rw_iswb), .rw_isld(rw_isld),
        .rw_iscall(rw_iscall), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    // Expected outputs, kept as "is an access outstanding, and for how many cycles".
    bit          m_busy = 0;
    int          m_waited = 0;
    logic [31:0] p_alu = 0, p_pc = 0, p_op2 = 0;
    logic [3:0]  p_rd = 0;
    bit          p_isld = 0, p_isst = 0, p_iswb = 0, p_iscall = 0;
    bit          m_req = 0, m_we = 0, m_rwv = 0, m_err = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [31:0] m_alu = 0, m_ld = 0, m_pc = 0;
    logic [3:0]  m_rd = 0;
    bit          m_iswb = 0, m_isld = 0, m_iscall = 0;

    task automatic retire(input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                          input logic [3:0] rd, input bit wb, input bit ld_f, input bit call);
        m_rwv = 1; m_alu = alu; m_ld = ld; m_pc = pc; m_rd = rd;
        m_iswb = wb; m_isld = ld_f; m_iscall = call;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_waited = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
            m_rwv = 0; m_err = 0;
            retire(0, 0, 0, 0, 0, 0, 0);
            m_rwv = 0;
        end else begin
            m_rwv = 0;
            if (!m_busy) begin
                if (ex_valid) begin
                    if (ex_isld || ex_isst) begin
                        if (ex_aluresult % 4 == 0) begin
                            m_busy = 1; m_waited = 0;
                            p_alu = ex_aluresult; p_op2 = ex_op2; p_pc = ex_pc; p_rd = ex_rd;
                            p_isld = ex_isld; p_isst = ex_isst; p_iswb = ex_iswb; p_iscall = ex_iscall;
                            m_req = 1; m_we = ex_isst; m_addr = ex_aluresult; m_wdata = ex_op2;
                        end else begin
                            retire(ex_aluresult, 0, ex_pc, ex_rd, 0, ex_isld, ex_iscall);
                            m_err = 1;
                        end
                    end else begin
                        retire(ex_aluresult, 0, ex_pc, ex_rd, ex_iswb, ex_isld, ex_iscall);
                    end
                end
            end else begin
                m_waited = m_waited + 1;
                if (dmem_ack) begin
                    m_busy = 0; m_req = 0;
                    retire(p_alu, (p_isld && !p_isst) ? dmem_rdata : 32'h0, p_pc, p_rd,
                           p_iswb, p_isld, p_iscall);
                end else if (m_waited == MEM_TIMEOUT) begin
                    m_busy = 0; m_req = 0;
                    retire(p_alu, 0, p_pc, p_rd, 0, p_isld, p_iscall);
                    m_err = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("ex_ready", ex_ready, !m_busy);
            checkOutput("dmem_req", dmem_req, m_req);
            checkOutput("dmem_we", dmem_we, m_we);
            checkOutput("dmem_addr", dmem_addr, m_addr);
            checkOutput("dmem_wdata", dmem_wdata, m_wdata);
            checkOutput("rw_valid", rw_valid, m_rwv);
            checkOutput("rw_aluresult", rw_aluresult, m_alu);
            checkOutput("rw_ldresult", rw_ldresult, m_ld);
            checkOutput("rw_pc", rw_pc, m_pc);
            checkOutput("rw_rd", rw_rd, m_rd);
            checkOutput("rw_flags", {rw_iswb, rw_isld, rw_iscall}, {m_iswb, m_isld, m_iscall});
            checkOutput("mem_error", mem_error, m_err);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] alu, input logic [31:0] op2,
                                 input logic [31:0] pc, input logic [3:0] rd, input bit ld,
                                 input bit st, input bit wb, input bit call);
        ex_valid = v; ex_aluresult = alu; ex_op2 = op2; ex_pc = pc; ex_rd = rd;
        ex_isld = ld; ex_isst = st; ex_iswb = wb; ex_iscall = call;
    endtask

    // Present one instruction for a single edge, then go quiet.
    task automatic issue(input logic [31:0] alu, input logic [31:0] op2, input logic [31:0] pc,
                         input logic [3:0] rd, input bit ld, input bit st, input bit wb, input bit call);
        applyStimulus(1, alu, op2, pc, rd, ld, st, wb, call);
        step;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset;
        reset = 1;
        step;
        reset = 0;
    endtask

    initial begin
        reset = 1; dmem_ack = 0; dmem_rdata = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step;
        reset = 0;
        @(negedge clk);
        checkOutput("reset_ex_ready", ex_ready, 1);
        checkOutput("reset_dmem_req", dmem_req, 0);
        checkOutput("reset_rw_valid", rw_valid, 0);
        checkOutput("reset_mem_error", mem_error, 0);
        checking = 1;

        // ALU pass-through
        issue(32'h10, 0, 32'h1000, 3, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("alu_rw_valid", rw_valid, 1);
        checkOutput("alu_rw_aluresult", rw_aluresult, 32'h10);
        checkOutput("alu_rw_rd", rw_rd, 3);
        checkOutput("alu_rw_iswb", rw_iswb, 1);
        checkOutput("alu_dmem_req", dmem_req, 0);
        checkOutput("alu_ex_ready", ex_ready, 1);

        // Load acked on the third WAIT cycle
        issue(32'h100, 0, 32'h1004, 5, 1, 0, 1, 0);
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            checkOutput("ld_dmem_req", dmem_req, 1);
            checkOutput("ld_dmem_addr", dmem_addr, 32'h100);
            checkOutput("ld_dmem_we", dmem_we, 0);
            checkOutput("ld_ex_ready", ex_ready, 0);
            if (w == 3) begin
                dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
            end
            step;
        end
        dmem_ack = 0; dmem_rdata = 0;
        @(negedge clk);
        checkOutput("ld_rw_valid", rw_valid, 1);
        checkOutput("ld_rw_ldresult", rw_ldresult, 32'hDEADBEEF);
        checkOutput("ld_rw_isld", rw_isld, 1);
        checkOutput("ld_done_req", dmem_req, 0);

        // Store acked on the first WAIT cycle, then a back-to-back ALU op
        issue(32'h204, 32'h12345678, 32'h1008, 0, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("st_dmem_we", dmem_we, 1);
        checkOutput("st_dmem_wdata", dmem_wdata, 32'h12345678);
        checkOutput("st_dmem_req", dmem_req, 1);
        dmem_ack = 1;
        step;
        dmem_ack = 0;
        applyStimulus(1, 32'h55, 0, 32'h100C, 7, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("st_rw_valid", rw_valid, 1);
        checkOutput("st_rw_ldresult", rw_ldresult, 0);
        checkOutput("st_ex_ready", ex_ready, 1);
        step;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("b2b_rw_valid", rw_valid, 1);
        checkOutput("b2b_rw_aluresult", rw_aluresult, 32'h55);
        checkOutput("b2b_rw_rd", rw_rd, 7);

        // Misaligned load
        issue(32'h102, 0, 32'h1010, 4, 1, 0, 1, 0);
        @(negedge clk);
        checkOutput("mis_rw_valid", rw_valid, 1);
        checkOutput("mis_rw_iswb", rw_iswb, 0);
        checkOutput("mis_mem_error", mem_error, 1);
        checkOutput("mis_dmem_req", dmem_req, 0);
        repeat (3) step;
        @(negedge clk);
        checkOutput("mis_error_sticky", mem_error, 1);
        doReset;

        // Timeout with no ack
        issue(32'h300, 0, 32'h1014, 6, 1, 0, 1, 0);
        repeat (MEM_TIMEOUT - 1) step;
        @(negedge clk);
        checkOutput("to_last_wait_req", dmem_req, 1);
        checkOutput("to_last_wait_ready", ex_ready, 0);
        step;
        @(negedge clk);
        checkOutput("to_dmem_req", dmem_req, 0);
        checkOutput("to_rw_valid", rw_valid, 1);
        checkOutput("to_rw_iswb", rw_iswb, 0);
        checkOutput("to_mem_error", mem_error, 1);
        doReset;

        // Ack on the very last allowed WAIT cycle completes normally
        issue(32'h304, 0, 32'h1018, 2, 1, 0, 1, 0);
        repeat (MEM_TIMEOUT - 1) step;
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        step;
        dmem_ack = 0; dmem_rdata = 0;
        @(negedge clk);
        checkOutput("late_rw_valid", rw_valid, 1);
        checkOutput("late_rw_iswb", rw_iswb, 1);
        checkOutput("late_rw_ldresult", rw_ldresult, 32'hCAFEF00D);
        checkOutput("late_mem_error", mem_error, 0);

        // Reset on the second WAIT cycle abandons the load
        issue(32'h400, 0, 32'h101C, 9, 1, 0, 1, 0);
        step;
        reset = 1;
        step;
        reset = 0;
        @(negedge clk);
        checkOutput("rst_dmem_req", dmem_req, 0);
        checkOutput("rst_ex_ready", ex_ready, 1);
        checkOutput("rst_rw_valid", rw_valid, 0);
        checkOutput("rst_rw_aluresult", rw_aluresult, 0);
        checkOutput("rst_rw_rd", rw_rd, 0);
        checkOutput("rst_rw_iswb", rw_iswb, 0);
        checkOutput("rst_mem_error", mem_error, 0);
        dmem_ack = 1; dmem_rdata = 32'h11111111;
        repeat (2) step;
        dmem_ack = 0;
        @(negedge clk);
        checkOutput("idle_ack_rw_valid", rw_valid, 0);
        repeat (2) step;

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
